// File: rtl/keypad_scan_ik.sv
// ---------------------------------------------------------------------------
// keypad_scan_ik
// Scans a 4x4 hex key matrix, debounces it over whole scans, and reports
// single-key presses as 4-bit codes (row*4+col) over a valid/ready handshake.
// Every press (delivered or dropped) is also shifted into a 16-bit hex entry
// word, newest digit in the low nibble.
//
// Ports
//   CLK        in   1   system clock
//   RSTN       in   1   asynchronous active-low reset
//   KEY_ROW    out  4   row drive, active-low one-hot
//   KEY_COL    in   4   column sense, active-low
//   key_code   out  4   code of last accepted press
//   key_valid  out  1   key_code holds an unconsumed press
//   key_ready  in   1   consumer takes key_code when key_valid & key_ready
//   key_down   out  1   debounced "any key held" level
//   key_ovf    out  1   sticky: a press was dropped while key_valid pending
//   ovf_clr    in   1   synchronous clear of key_ovf
//   entry      out  16  hex entry word
//   entry_clr  in   1   synchronous clear of entry
// ---------------------------------------------------------------------------
module keypad_scan_ik #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEB_CNT  = 3
) (
    input  logic        CLK,
    input  logic        RSTN,
    output logic [3:0]  KEY_ROW,
    input  logic [3:0]  KEY_COL,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        key_down,
    output logic        key_ovf,
    input  logic        ovf_clr,
    output logic [15:0] entry,
    input  logic        entry_clr
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEB_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CNT);

    // True when exactly one bit of the snapshot is set.
    function automatic logic is_onehot16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return (n == 5'd1);
    endfunction

    // Bit position of the (single) set bit, which is already row*4+col.
    function automatic logic [3:0] encode16(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // ---------------- scan state ----------------
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       row_q, row_d;
    logic [3:0]       key_row_q, key_row_d;
    logic [15:0]      snap_q, snap_d;
    logic             scan_end_q, scan_end_d;

    // ---------------- debounce state ----------------
    logic [15:0]      prev_q, prev_d;
    logic [15:0]      deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             key_down_q, key_down_d;
    logic             event_q, event_d;
    logic [3:0]       event_code_q, event_code_d;

    // ---------------- handshake / entry state ----------------
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_ovf_q, key_ovf_d;
    logic [15:0]      entry_q, entry_d;
    logic             drop_s;

    // Row divider: sample the columns of the driven row on its last cycle,
    // then step to the next row; the row after row 3 marks a completed scan.
    always_comb begin
        div_d      = div_q;
        row_d      = row_q;
        key_row_d  = key_row_q;
        snap_d     = snap_q;
        scan_end_d = 1'b0;
        if (div_q == DIV_LAST) begin
            div_d  = '0;
            row_d  = row_q + 2'd1;
            key_row_d = ~(4'b0001 << row_d);
            snap_d[{row_q, 2'b00} +: 4] = ~KEY_COL;
            scan_end_d = (row_q == 2'd3);
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Debounce at scan end: count consecutive identical scans; the state is
    // accepted only on the scan where the count first reaches DEB_CNT, so a
    // long-held state is not re-accepted every scan.
    always_comb begin
        cnt_inc_s    = cnt_q + CNT_W'(1);
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        deb_d        = deb_q;
        key_down_d   = key_down_q;
        event_d      = 1'b0;
        event_code_d = event_code_q;
        if (scan_end_q) begin
            prev_d = snap_q;
            if (snap_q == prev_q) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == CNT_MAX) begin
                        deb_d      = snap_q;
                        key_down_d = |snap_q;
                        // A press only counts when coming from "nothing held";
                        // multi-key states never re-arm.
                        if ((deb_q == 16'h0000) && is_onehot16(snap_q)) begin
                            event_d      = 1'b1;
                            event_code_d = encode16(snap_q);
                        end else begin
                            event_d = 1'b0;
                        end
                    end else begin
                        deb_d = deb_q;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                cnt_d = '0;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Handshake, overflow flag and entry shift register.
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        key_ovf_d   = key_ovf_q;
        entry_d     = entry_q;
        drop_s      = 1'b0;
        if (event_q) begin
            if (!key_valid_q || key_ready) begin
                key_code_d  = event_code_q;
                key_valid_d = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else if (key_valid_q && key_ready) begin
            key_valid_d = 1'b0;
        end else begin
            key_valid_d = key_valid_q;
        end

        // A drop in the same cycle as ovf_clr wins, so no drop goes unseen.
        if (drop_s) begin
            key_ovf_d = 1'b1;
        end else if (ovf_clr) begin
            key_ovf_d = 1'b0;
        end else begin
            key_ovf_d = key_ovf_q;
        end

        if (entry_clr) begin
            entry_d = 16'h0000;
        end else if (event_q) begin
            entry_d = {entry_q[11:0], event_code_q};
        end else begin
            entry_d = entry_q;
        end
    end

    // State registers for scan, debounce and handshake.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            div_q        <= '0;
            row_q        <= 2'd0;
            key_row_q    <= 4'b1110;
            snap_q       <= 16'h0000;
            scan_end_q   <= 1'b0;
            prev_q       <= 16'h0000;
            deb_q        <= 16'h0000;
            cnt_q        <= '0;
            key_down_q   <= 1'b0;
            event_q      <= 1'b0;
            event_code_q <= 4'h0;
            key_code_q   <= 4'h0;
            key_valid_q  <= 1'b0;
            key_ovf_q    <= 1'b0;
            entry_q      <= 16'h0000;
        end else begin
            div_q        <= div_d;
            row_q        <= row_d;
            key_row_q    <= key_row_d;
            snap_q       <= snap_d;
            scan_end_q   <= scan_end_d;
            prev_q       <= prev_d;
            deb_q        <= deb_d;
            cnt_q        <= cnt_d;
            key_down_q   <= key_down_d;
            event_q      <= event_d;
            event_code_q <= event_code_d;
            key_code_q   <= key_code_d;
            key_valid_q  <= key_valid_d;
            key_ovf_q    <= key_ovf_d;
            entry_q      <= entry_d;
        end
    end

    assign KEY_ROW   = key_row_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;
    assign key_ovf   = key_ovf_q;
    assign entry     = entry_q;

endmodule
